// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: shared MIPS ISA constants for the loader and the core's decoder.
// Contents: opcode/funct codes, the 5-bit mnemonic enumeration accepted by the
// loader (codes 0..28, 29..31 illegal), and the loader FSM state encodings.
package mips_isa_pkg;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SH    = 6'b101001;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type function codes
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   // Mnemonic codes as presented on the loader input stream
   typedef enum logic [4:0] {
      MN_ADD   = 5'd0,  MN_ADDI = 5'd1,  MN_ADDIU = 5'd2,  MN_ADDU = 5'd3,
      MN_AND   = 5'd4,  MN_ANDI = 5'd5,  MN_BEQ   = 5'd6,  MN_BNE  = 5'd7,
      MN_J     = 5'd8,  MN_JAL  = 5'd9,  MN_JR    = 5'd10, MN_LBU  = 5'd11,
      MN_LHU   = 5'd12, MN_LUI  = 5'd13, MN_LW    = 5'd14, MN_NOR  = 5'd15,
      MN_OR    = 5'd16, MN_ORI  = 5'd17, MN_SLT   = 5'd18, MN_SLTI = 5'd19,
      MN_SLTIU = 5'd20, MN_SLTU = 5'd21, MN_SLL   = 5'd22, MN_SRL  = 5'd23,
      MN_SB    = 5'd24, MN_SH   = 5'd25, MN_SW    = 5'd26, MN_SUB  = 5'd27,
      MN_SUBU  = 5'd28
   } mnem_e;

   localparam logic [4:0] MNEM_LAST = 5'd28;

   // Loader FSM states
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/mips_instr_pack.sv
// mips_instr_pack: combinational encoder from symbolic fields to a MIPS word.
// Ports: mnem/rs/rt/rd/shamt/imm/target in; word (32-bit encoding) and legal
// (mnemonic is within 0..MNEM_LAST) out. Illegal mnemonics yield word = 0.
module mips_instr_pack
   import mips_isa_pkg::*;
(
   input  logic [4:0]  mnem,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        legal
);

   function automatic logic [31:0] r_word(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                          input logic [4:0] f_rd, input logic [4:0] f_sh,
                                          input logic [5:0] f_fn);
      return {OP_RTYPE, f_rs, f_rt, f_rd, f_sh, f_fn};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] f_op, input logic [4:0] f_rs,
                                          input logic [4:0] f_rt, input logic [15:0] f_imm);
      return {f_op, f_rs, f_rt, f_imm};
   endfunction

   // Field packing per mnemonic; shamt is only meaningful for the shifts,
   // and the shifts/LUI ignore rs so the emitted word is canonical.
   always_comb begin
      word  = 32'h0000_0000;
      legal = (mnem <= MNEM_LAST);
      case (mnem)
         MN_ADD:   word = r_word(rs, rt, rd, 5'd0, FN_ADD);
         MN_ADDU:  word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
         MN_SUB:   word = r_word(rs, rt, rd, 5'd0, FN_SUB);
         MN_SUBU:  word = r_word(rs, rt, rd, 5'd0, FN_SUBU);
         MN_AND:   word = r_word(rs, rt, rd, 5'd0, FN_AND);
         MN_OR:    word = r_word(rs, rt, rd, 5'd0, FN_OR);
         MN_NOR:   word = r_word(rs, rt, rd, 5'd0, FN_NOR);
         MN_SLT:   word = r_word(rs, rt, rd, 5'd0, FN_SLT);
         MN_SLTU:  word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
         MN_SLL:   word = r_word(5'd0, rt, rd, shamt, FN_SLL);
         MN_SRL:   word = r_word(5'd0, rt, rd, shamt, FN_SRL);
         MN_JR:    word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
         MN_ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
         MN_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm);
         MN_SLTI:  word = i_word(OP_SLTI, rs, rt, imm);
         MN_SLTIU: word = i_word(OP_SLTIU, rs, rt, imm);
         MN_ANDI:  word = i_word(OP_ANDI, rs, rt, imm);
         MN_ORI:   word = i_word(OP_ORI, rs, rt, imm);
         MN_LUI:   word = i_word(OP_LUI, 5'd0, rt, imm);
         MN_BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
         MN_BNE:   word = i_word(OP_BNE, rs, rt, imm);
         MN_LBU:   word = i_word(OP_LBU, rs, rt, imm);
         MN_LHU:   word = i_word(OP_LHU, rs, rt, imm);
         MN_LW:    word = i_word(OP_LW, rs, rt, imm);
         MN_SB:    word = i_word(OP_SB, rs, rt, imm);
         MN_SH:    word = i_word(OP_SH, rs, rt, imm);
         MN_SW:    word = i_word(OP_SW, rs, rt, imm);
         MN_J:     word = {OP_J, target};
         MN_JAL:   word = {OP_JAL, target};
         default: begin
            word  = 32'h0000_0000;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mips_program_loader.sv
// mips_program_loader: turns a valid/ready stream of symbolic instructions into
// sequential instruction-memory writes starting at a programmable address.
// Ports: clk, rst (sync, active-high); start/base_addr arm a load; in_* is the
//   instruction stream (in_ready high only in RUN); wr_en/wr_addr/wr_data is the
//   memory write port (one cycle after acceptance); busy/done/err_illegal/
//   word_count report load status.
module mips_program_loader
   import mips_isa_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [4:0]        in_mnem,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              err_illegal,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   logic [1:0]        state_r;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W:0]   count_r;
   logic              err_r;
   logic              wr_en_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [31:0]       wr_data_r;
   logic [31:0]       word_s;
   logic              legal_s;
   logic              accept_s;

   mips_instr_pack u_pack (
      .mnem   (in_mnem),
      .rs     (in_rs),
      .rt     (in_rt),
      .rd     (in_rd),
      .shamt  (in_shamt),
      .imm    (in_imm),
      .target (in_target),
      .word   (word_s),
      .legal  (legal_s)
   );

   // Handshake and status decode, all derived from the state register
   always_comb begin
      in_ready = (state_r == RUN);
      busy     = (state_r == RUN);
      done     = (state_r == DONE);
      accept_s = in_valid && (state_r == RUN);
   end

   // FSM, address/count bookkeeping and the write output stage
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         addr_r    <= {ADDR_W{1'b0}};
         count_r   <= {(ADDR_W+1){1'b0}};
         err_r     <= 1'b0;
         wr_en_r   <= 1'b0;
         wr_addr_r <= {ADDR_W{1'b0}};
         wr_data_r <= 32'h0000_0000;
      end else begin
         wr_en_r <= 1'b0;
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  state_r <= RUN;
                  addr_r  <= base_addr;
                  count_r <= {(ADDR_W+1){1'b0}};
                  err_r   <= 1'b0;
               end
            end
            RUN: begin
               if (accept_s) begin
                  // Illegal beats are swallowed: flag them but leave addr/count alone
                  if (legal_s) begin
                     wr_en_r   <= 1'b1;
                     wr_addr_r <= addr_r;
                     wr_data_r <= word_s;
                     addr_r    <= addr_r + ADDR_ONE;
                     if (count_r != COUNT_MAX) begin
                        count_r <= count_r + COUNT_ONE;
                     end
                  end else begin
                     err_r <= 1'b1;
                  end
                  if (in_last) begin
                     state_r <= DONE;
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // A write still sitting in the output stage when reset arrives is dropped
   always_comb begin
      wr_en       = wr_en_r && !rst;
      wr_addr     = wr_addr_r;
      wr_data     = wr_data_r;
      err_illegal = err_r;
      word_count  = count_r;
   end

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed self-checking bench for mips_program_loader with hand-computed
// encodings. Inputs change #1 after a rising edge; outputs are checked there.
module tb_mips_program_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  base_addr = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_last = 1'b0;
   logic [4:0]  in_mnem = 5'd0;
   logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
   logic [15:0] in_imm = 16'h0000;
   logic [25:0] in_target = 26'h0;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        busy, done, err_illegal;
   logic [8:0]  word_count;

   int n_checks = 0;
   int n_fails  = 0;

   mips_program_loader #(.ADDR_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err_illegal(err_illegal), .word_count(word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic last);
      in_valid = 1'b1; in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd;
      in_shamt = sh; in_imm = imm; in_target = tgt; in_last = last;
   endtask

   task automatic idle_in();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic arm(input logic [7:0] base);
      start = 1'b1; base_addr = base;
      step();
      start = 1'b0;
   endtask

   initial begin
      // Reset state
      step(); step();
      rst = 1'b0;
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_err", 32'(err_illegal), 32'd0);
      chk("rst_count", 32'(word_count), 32'd0);
      chk("rst_addr", 32'(wr_addr), 32'd0);
      chk("rst_data", wr_data, 32'd0);

      // Load at 0x10: ADD, LW, SLL(last) back-to-back
      arm(8'h10);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_ready", 32'(in_ready), 32'd1);
      beat(5'd0, 5'd8, 5'd9, 5'd10, 5'd0, 16'h0, 26'h0, 1'b0);      // ADD
      step();
      beat(5'd14, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b0);  // LW
      chk("add_wr_en", 32'(wr_en), 32'd1);
      chk("add_addr", 32'(wr_addr), 32'h10);
      chk("add_data", wr_data, 32'h0109_5020);
      chk("add_count", 32'(word_count), 32'd1);
      step();
      beat(5'd22, 5'd5, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0, 1'b1);      // SLL last
      chk("lw_wr_en", 32'(wr_en), 32'd1);
      chk("lw_addr", 32'(wr_addr), 32'h11);
      chk("lw_data", wr_data, 32'h8FA8_0004);
      chk("lw_done", 32'(done), 32'd0);
      step();
      idle_in();
      chk("sll_wr_en", 32'(wr_en), 32'd1);
      chk("sll_addr", 32'(wr_addr), 32'h12);
      chk("sll_data", wr_data, 32'h0003_1100);
      chk("sll_done", 32'(done), 32'd1);
      chk("sll_ready", 32'(in_ready), 32'd0);
      chk("sll_count", 32'(word_count), 32'd3);
      step();
      chk("after_wr_en", 32'(wr_en), 32'd0);
      chk("after_done", 32'(done), 32'd1);

      // Load at 0xFF: J, JR, BEQ with address wrap
      arm(8'hFF);
      chk("rearm_done", 32'(done), 32'd0);
      chk("rearm_count", 32'(word_count), 32'd0);
      beat(5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40, 1'b0);      // J
      step();
      beat(5'd10, 5'd31, 5'd7, 5'd7, 5'd7, 16'h0, 26'h0, 1'b0);     // JR
      chk("j_addr", 32'(wr_addr), 32'hFF);
      chk("j_data", wr_data, 32'h0800_0040);
      step();
      beat(5'd6, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b1);    // BEQ last
      chk("jr_addr_wrap", 32'(wr_addr), 32'h00);
      chk("jr_data", wr_data, 32'h03E0_0008);
      chk("jr_count", 32'(word_count), 32'd2);
      step();
      idle_in();
      chk("beq_addr", 32'(wr_addr), 32'h01);
      chk("beq_data", wr_data, 32'h1022_FFFF);
      chk("beq_done", 32'(done), 32'd1);

      // Illegal mnemonic between two legal beats
      arm(8'h20);
      beat(5'd13, 5'd5, 5'd4, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0);   // LUI
      step();
      beat(5'd30, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0);      // illegal
      chk("lui_addr", 32'(wr_addr), 32'h20);
      chk("lui_data", wr_data, 32'h3C04_1234);
      step();
      beat(5'd16, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'h0, 1'b1);      // OR last
      chk("ill_wr_en", 32'(wr_en), 32'd0);
      chk("ill_err", 32'(err_illegal), 32'd1);
      chk("ill_count", 32'(word_count), 32'd1);
      step();
      idle_in();
      chk("or_wr_en", 32'(wr_en), 32'd1);
      chk("or_addr", 32'(wr_addr), 32'h21);
      chk("or_data", wr_data, 32'h0022_1825);
      chk("or_count", 32'(word_count), 32'd2);
      chk("or_err_sticky", 32'(err_illegal), 32'd1);
      arm(8'h40);
      chk("start_clr_err", 32'(err_illegal), 32'd0);

      // Illegal final beat still ends the load, without a write
      beat(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
      step();
      idle_in();
      chk("ill_last_wr_en", 32'(wr_en), 32'd0);
      chk("ill_last_done", 32'(done), 32'd1);
      chk("ill_last_err", 32'(err_illegal), 32'd1);
      chk("ill_last_count", 32'(word_count), 32'd0);

      // Reset mid-load drops the pending write
      arm(8'h50);
      beat(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);       // ADDU
      step();
      idle_in();
      rst = 1'b1;
      #1;
      chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
      step();
      rst = 1'b0;
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      chk("rst_mid_ready", 32'(in_ready), 32'd0);
      chk("rst_mid_count", 32'(word_count), 32'd0);
      step();
      chk("rst_stay_idle", 32'(busy), 32'd0);
      chk("rst_no_write", 32'(wr_en), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
